// File: rtl/wts_pkg.sv
// Shared definitions for the wave-table SRAM scheduler: state encoding,
// wave-table field widths and the default channel count.
package wts_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CH_SLOT  = 2'd1,
      CPU_SLOT = 2'd2,
      DONE     = 2'd3
   } wts_state_e;

   localparam int WAVE_ADDR_W    = 7;
   localparam int SAMPLE_W       = 8;
   localparam int NUM_CH_DEFAULT = 5;

endpackage

// File: rtl/wts_sram_scheduler_if.sv
// SRAM port and CPU access bus of the wave-table scheduler. The slave modport
// is the scheduler; the master modport is the SRAM plus CPU bus decoder side.
interface wts_sram_scheduler_if #(
   parameter int ADDR_W = 10
);
   logic [ADDR_W-1:0] sram_a;
   logic              sram_we;
   logic [7:0]        sram_d;
   logic [7:0]        sram_q;
   logic              cpu_req;
   logic              cpu_wr;
   logic [ADDR_W-1:0] cpu_a;
   logic [7:0]        cpu_wdata;
   logic [7:0]        cpu_rdata;
   logic              cpu_ack;

   modport slave (
      output sram_a, sram_we, sram_d, cpu_rdata, cpu_ack,
      input  sram_q, cpu_req, cpu_wr, cpu_a, cpu_wdata
   );

   modport master (
      input  sram_a, sram_we, sram_d, cpu_rdata, cpu_ack,
      output sram_q, cpu_req, cpu_wr, cpu_a, cpu_wdata
   );
endinterface

// File: rtl/wts_sample_latch.sv
// Per-channel wave-data register bank: one indexed write per cycle, every
// other entry holds.
module wts_sample_latch
   import wts_pkg::*;
#(
   parameter int NUM_CH = NUM_CH_DEFAULT,
   parameter int CH_W   = 3
) (
   input  logic                       clk,
   input  logic                       nreset,
   input  logic                       we,
   input  logic [CH_W-1:0]            idx,
   input  logic [SAMPLE_W-1:0]        din,
   output logic [NUM_CH*SAMPLE_W-1:0] wave_data
);

   logic [NUM_CH*SAMPLE_W-1:0] wave_data_r;

   // Indexed sample register write with synchronous clear.
   always_ff @(posedge clk) begin
      if (!nreset) begin
         wave_data_r <= {(NUM_CH*SAMPLE_W){1'b0}};
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (we && (idx == CH_W'(i))) begin
               wave_data_r[i*SAMPLE_W +: SAMPLE_W] <= din;
            end else begin
               wave_data_r[i*SAMPLE_W +: SAMPLE_W] <= wave_data_r[i*SAMPLE_W +: SAMPLE_W];
            end
         end
      end
   end

   assign wave_data = wave_data_r;

endmodule

// File: rtl/wts_sram_scheduler.sv
// Time-division scheduler for the shared wave-table SRAM: one read slot per
// channel, then one CPU slot. Optional macro WTS_CH_MUTE_SKIP_EN zeroes muted slots.
module wts_sram_scheduler
   import wts_pkg::*;
#(
   parameter int NUM_CH = NUM_CH_DEFAULT,
   parameter int CH_W   = 3,
   parameter int ADDR_W = CH_W + 7
) (
   input  logic                          clk,
   input  logic                          nreset,
   input  logic                          active,
   input  logic [NUM_CH*WAVE_ADDR_W-1:0] ch_sram_a,
   input  logic [NUM_CH-1:0]             ch_mute,
   output logic [NUM_CH*SAMPLE_W-1:0]    wave_data,
   output logic                          sample_valid,
   output logic                          overrun,
   wts_sram_scheduler_if.slave           bus
);

   localparam logic [CH_W-1:0] LAST_SLOT = CH_W'(NUM_CH - 1);

   wts_state_e          state_r;
   logic [CH_W-1:0]     slot_r;
   logic                granted_r;
   logic                grant_wr_r;
   logic [ADDR_W-1:0]   sram_a_r;
   logic                sram_we_r;
   logic [7:0]          sram_d_r;
   logic                cpu_ack_r;
   logic [7:0]          rdata_r;
   logic                sample_valid_r;
   logic                overrun_r;

   logic [CH_W-1:0]        next_slot_s;
   logic [WAVE_ADDR_W-1:0] ch_wave_s;
   logic                   ch_mute_s;
   logic [ADDR_W-1:0]      ch_word_s;
   logic                   lat_we_s;
   logic [CH_W-1:0]        lat_idx_s;
   logic [SAMPLE_W-1:0]    lat_din_s;

   // Select the wave address and mute bit of the slot about to be presented.
   always_comb begin
      next_slot_s = (state_r == IDLE) ? {CH_W{1'b0}} : (slot_r + CH_W'(1));
      ch_wave_s   = {WAVE_ADDR_W{1'b0}};
      ch_mute_s   = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         ch_wave_s = (next_slot_s == CH_W'(i)) ? ch_sram_a[i*WAVE_ADDR_W +: WAVE_ADDR_W] : ch_wave_s;
         ch_mute_s = (next_slot_s == CH_W'(i)) ? ch_mute[i] : ch_mute_s;
      end
   end

   // The sample returned in a slot belongs to the channel presented one cycle earlier.
   always_comb begin
      lat_we_s  = 1'b0;
      lat_idx_s = {CH_W{1'b0}};
      if (state_r == CH_SLOT) begin
         lat_we_s  = (slot_r != {CH_W{1'b0}});
         lat_idx_s = slot_r - CH_W'(1);
      end else if (state_r == CPU_SLOT) begin
         lat_we_s  = 1'b1;
         lat_idx_s = LAST_SLOT;
      end else begin
         lat_we_s  = 1'b0;
         lat_idx_s = {CH_W{1'b0}};
      end
   end

`ifdef WTS_CH_MUTE_SKIP_EN
   logic cur_mute_r;
   logic lat_zero_r;

   // Remember which presented slot was muted so its sample is zeroed next cycle.
   always_ff @(posedge clk) begin
      if (!nreset) begin
         cur_mute_r <= 1'b0;
         lat_zero_r <= 1'b0;
      end else begin
         lat_zero_r <= cur_mute_r;
         cur_mute_r <= ((state_r == IDLE && active) || (state_r == CH_SLOT && slot_r != LAST_SLOT))
                       ? ch_mute_s : 1'b0;
      end
   end

   // Muted slots present address 0 and store a silent sample.
   always_comb begin
      ch_word_s = ch_mute_s ? {ADDR_W{1'b0}} : ADDR_W'({next_slot_s, ch_wave_s});
      lat_din_s = lat_zero_r ? 8'h00 : bus.sram_q;
   end
`else
   logic unused_mute_s;
   assign unused_mute_s = ch_mute_s;

   // Every channel slot reads its own wave address.
   always_comb begin
      ch_word_s = ADDR_W'({next_slot_s, ch_wave_s});
      lat_din_s = bus.sram_q;
   end
`endif

   // Scan sequencer; outputs are registered on entry to the state that owns them.
   always_ff @(posedge clk) begin
      if (!nreset) begin
         state_r        <= IDLE;
         slot_r         <= {CH_W{1'b0}};
         granted_r      <= 1'b0;
         grant_wr_r     <= 1'b0;
         sram_a_r       <= {ADDR_W{1'b0}};
         sram_we_r      <= 1'b0;
         sram_d_r       <= 8'h00;
         cpu_ack_r      <= 1'b0;
         rdata_r        <= 8'h00;
         sample_valid_r <= 1'b0;
         overrun_r      <= 1'b0;
      end else begin
         sram_we_r      <= 1'b0;
         cpu_ack_r      <= 1'b0;
         sample_valid_r <= 1'b0;
         if (active && (state_r != IDLE)) begin
            overrun_r <= 1'b1;
         end else begin
            overrun_r <= overrun_r;
         end
         case (state_r)
            IDLE: begin
               if (active) begin
                  state_r  <= CH_SLOT;
                  slot_r   <= {CH_W{1'b0}};
                  sram_a_r <= ch_word_s;
               end else begin
                  state_r  <= IDLE;
                  sram_a_r <= {ADDR_W{1'b0}};
               end
            end
            CH_SLOT: begin
               if (slot_r == LAST_SLOT) begin
                  state_r    <= CPU_SLOT;
                  granted_r  <= bus.cpu_req;
                  grant_wr_r <= bus.cpu_wr;
                  if (bus.cpu_req) begin
                     sram_a_r  <= bus.cpu_a;
                     sram_we_r <= bus.cpu_wr;
                     sram_d_r  <= bus.cpu_wr ? bus.cpu_wdata : 8'h00;
                  end else begin
                     sram_a_r  <= {ADDR_W{1'b0}};
                     sram_d_r  <= 8'h00;
                  end
               end else begin
                  slot_r   <= slot_r + CH_W'(1);
                  sram_a_r <= ch_word_s;
               end
            end
            CPU_SLOT: begin
               state_r        <= DONE;
               sram_a_r       <= {ADDR_W{1'b0}};
               sram_d_r       <= 8'h00;
               sample_valid_r <= 1'b1;
               cpu_ack_r      <= granted_r;
            end
            DONE: begin
               state_r   <= IDLE;
               granted_r <= 1'b0;
               if (granted_r && !grant_wr_r) begin
                  rdata_r <= bus.sram_q;
               end else begin
                  rdata_r <= rdata_r;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   wts_sample_latch #(
      .NUM_CH (NUM_CH),
      .CH_W   (CH_W)
   ) u_latch (
      .clk       (clk),
      .nreset    (nreset),
      .we        (lat_we_s),
      .idx       (lat_idx_s),
      .din       (lat_din_s),
      .wave_data (wave_data)
   );

   assign bus.sram_a    = sram_a_r;
   assign bus.sram_we   = sram_we_r;
   assign bus.sram_d    = sram_d_r;
   assign bus.cpu_ack   = cpu_ack_r;
   assign bus.cpu_rdata = (state_r == DONE && granted_r && !grant_wr_r) ? bus.sram_q : rdata_r;
   assign sample_valid  = sample_valid_r;
   assign overrun       = overrun_r;

endmodule

// File: tb/tb_wts_sram_scheduler.sv
// Directed bench for wts_sram_scheduler with a synchronous-read SRAM model;
// honours WTS_CH_MUTE_SKIP_EN for the mute expectations.
module tb_wts_sram_scheduler;

   logic        clk;
   logic        nreset;
   logic        active;
   logic [34:0] ch_sram_a;
   logic [4:0]  ch_mute;
   logic [39:0] wave_data;
   logic        sample_valid;
   logic        overrun;
   logic [7:0]  mem [1024];
   logic        exp_ov;
   int          checks;
   int          failures;

   logic [9:0] exp_addr [5] = '{10'h010, 10'h091, 10'h112, 10'h193, 10'h214};
   logic [7:0] exp_wave [5] = '{8'hB5, 8'h34, 8'hB7, 8'h36, 8'hB1};

   wts_sram_scheduler_if #(.ADDR_W(10)) bus ();

   wts_sram_scheduler #(.NUM_CH(5), .CH_W(3), .ADDR_W(10)) dut (
      .clk          (clk),
      .nreset       (nreset),
      .active       (active),
      .ch_sram_a    (ch_sram_a),
      .ch_mute      (ch_mute),
      .wave_data    (wave_data),
      .sample_valid (sample_valid),
      .overrun      (overrun),
      .bus          (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM model: write-through on sram_we, read data one cycle after the address.
   always @(posedge clk) begin
      if (bus.sram_we) mem[bus.sram_a] <= bus.sram_d;
      bus.sram_q <= mem[bus.sram_a];
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic muted_slot(input logic [4:0] m, input int k);
`ifdef WTS_CH_MUTE_SKIP_EN
      return m[k];
`else
      return 1'b0;
`endif
   endfunction

   // One full scan from the active pulse (cycle T) to T+8.
   task automatic do_scan(input logic grant, input logic wr, input logic [9:0] ca,
                          input logic [7:0] wd, input logic [7:0] rd, input int ov_at);
      active = 1'b1;
      tick();
      active = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         if (ov_at != 0 && k == ov_at + 1) exp_ov = 1'b1;
         chk("slot_addr", bus.sram_a, muted_slot(ch_mute, k-1) ? 10'h000 : exp_addr[k-1]);
         chk("slot_we", bus.sram_we, 1'b0);
         chk("slot_valid", sample_valid, 1'b0);
         chk("slot_overrun", overrun, exp_ov);
         active = (k == ov_at);
         tick();
      end
      active = 1'b0;
      chk("cpu_slot_we", bus.sram_we, grant & wr);
      chk("cpu_slot_addr", bus.sram_a, grant ? ca : 10'h000);
      if (grant && wr) chk("cpu_slot_d", bus.sram_d, wd);
      chk("cpu_slot_ack", bus.cpu_ack, 1'b0);
      tick();
      chk("done_valid", sample_valid, 1'b1);
      chk("done_ack", bus.cpu_ack, grant);
      chk("done_we", bus.sram_we, 1'b0);
      if (grant && !wr) chk("done_rdata", bus.cpu_rdata, rd);
      bus.cpu_req = 1'b0;
      tick();
      chk("post_valid", sample_valid, 1'b0);
      chk("post_ack", bus.cpu_ack, 1'b0);
      for (int i = 0; i < 5; i++) begin
         chk("wave_data", wave_data[i*8 +: 8], muted_slot(ch_mute, i) ? 8'h00 : exp_wave[i]);
      end
      tick();
   endtask

   initial begin
      checks = 0;
      failures = 0;
      exp_ov = 1'b0;
      for (int a = 0; a < 1024; a++) mem[a] = 8'(a) ^ 8'hA5;
      nreset = 1'b0;
      active = 1'b0;
      ch_sram_a = {7'h14, 7'h13, 7'h12, 7'h11, 7'h10};
      ch_mute = 5'b00000;
      bus.cpu_req = 1'b0;
      bus.cpu_wr = 1'b0;
      bus.cpu_a = 10'h000;
      bus.cpu_wdata = 8'h00;
      tick();
      tick();
      chk("rst_sram_a", bus.sram_a, 10'h000);
      chk("rst_we", bus.sram_we, 1'b0);
      chk("rst_ack", bus.cpu_ack, 1'b0);
      chk("rst_rdata", bus.cpu_rdata, 8'h00);
      chk("rst_valid", sample_valid, 1'b0);
      chk("rst_overrun", overrun, 1'b0);
      chk("rst_wave", wave_data, 40'h0);
      nreset = 1'b1;
      tick();

      // Basic scan, no CPU request.
      do_scan(1'b0, 1'b0, 10'h000, 8'h00, 8'h00, 0);

      // CPU write.
      bus.cpu_req = 1'b1; bus.cpu_wr = 1'b1; bus.cpu_a = 10'h0C5; bus.cpu_wdata = 8'h3C;
      do_scan(1'b1, 1'b1, 10'h0C5, 8'h3C, 8'h00, 0);
      chk("mem_written", mem[10'h0C5], 8'h3C);

      // CPU read of the written location; rdata then holds.
      bus.cpu_req = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_a = 10'h0C5;
      do_scan(1'b1, 1'b0, 10'h0C5, 8'h00, 8'h3C, 0);
      chk("rdata_hold", bus.cpu_rdata, 8'h3C);

      // Overrun: second pulse at T+3, no extra scan afterwards.
      do_scan(1'b0, 1'b0, 10'h000, 8'h00, 8'h00, 3);
      for (int c = 0; c < 8; c++) begin
         chk("idle_addr", bus.sram_a, 10'h000);
         chk("idle_valid", sample_valid, 1'b0);
         chk("idle_overrun", overrun, 1'b1);
         tick();
      end

      // Reset mid-scan with a pending write.
      bus.cpu_req = 1'b1; bus.cpu_wr = 1'b1; bus.cpu_a = 10'h0C6; bus.cpu_wdata = 8'h5A;
      active = 1'b1;
      tick();
      active = 1'b0;
      for (int k = 1; k <= 5; k++) tick();
      chk("pre_rst_we", bus.sram_we, 1'b1);
      nreset = 1'b0;
      tick();
      chk("mid_rst_we", bus.sram_we, 1'b0);
      chk("mid_rst_ack", bus.cpu_ack, 1'b0);
      chk("mid_rst_wave", wave_data, 40'h0);
      chk("mid_rst_valid", sample_valid, 1'b0);
      chk("mid_rst_overrun", overrun, 1'b0);
      chk("mid_rst_addr", bus.sram_a, 10'h000);
      exp_ov = 1'b0;
      nreset = 1'b1;
      tick();
      chk("rst_no_ack", bus.cpu_ack, 1'b0);
      mem[10'h0C6] = 8'h00;
      do_scan(1'b1, 1'b1, 10'h0C6, 8'h5A, 8'h00, 0);
      chk("mem_rewritten", mem[10'h0C6], 8'h5A);

      // Mute on channel 2.
      ch_mute = 5'b00100;
      do_scan(1'b0, 1'b0, 10'h000, 8'h00, 8'h00, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wts_sram_scheduler.md
Name: wts_sram_scheduler

Overview:
- Time-division scheduler for the single wave-table SRAM shared by all NUM_CH channel parts and the CPU register interface.
- On each 3.579 MHz `active` pulse it walks one read slot per channel, then one CPU slot.
- Each channel's wave address is merged with its channel index, and each returned sample is latched into a per-channel wave-data register for the mixer.
- It sits between the channel parts' `sram_a` outputs, the physical SRAM and the CPU bus decoder.

Parameters:
- NUM_CH, 5, number of channel parts sharing the SRAM (2..8).
- CH_W, 3, channel index width; must satisfy 2^CH_W >= NUM_CH.
- ADDR_W, CH_W+7, SRAM address width: {channel index, 7-bit wave address}.

Ports:
- clk  in  1  system clock; the only clock.
- nreset  in  1  reset; synchronous, active-low.
- active  in  1  3.579 MHz timing pulse, one clk wide.
- ch_sram_a  in  NUM_CH*7  packed channel wave addresses; channel i is at [i*7+6:i*7].
- ch_mute  in  NUM_CH  per-channel mute, used only with the optional feature.
- wave_data  out  NUM_CH*8  packed latched samples; channel i is at [i*8+7:i*8].
- sample_valid  out  1  one-cycle pulse when all wave_data entries for this period are updated.
- sram_a  out  ADDR_W  SRAM address.
- sram_we  out  1  SRAM write strobe.
- sram_d  out  8  SRAM write data.
- sram_q  in  8  SRAM read data, valid 1 cycle after sram_a.
- cpu_req  in  1  CPU access request, level, held until cpu_ack.
- cpu_wr  in  1  1 = write, 0 = read; stable while cpu_req is high.
- cpu_a  in  ADDR_W  CPU address.
- cpu_wdata  in  8  CPU write data.
- cpu_rdata  out  8  CPU read data, valid with cpu_ack.
- cpu_ack  out  1  one-cycle completion pulse.
- overrun  out  1  sticky flag: `active` arrived while a scan was in progress.

Behaviour:
- Reset values (nreset=0 at a clk edge): state IDLE, all outputs 0, wave_data all 0, overrun 0.
- Reset mid-scan aborts immediately. A pending CPU request is dropped with no ack, and the requester re-presents it.
- States: IDLE, CH_SLOT, CPU_SLOT, DONE. The slot counter `slot` is CH_W bits wide.
- IDLE: when active=1, go to CH_SLOT with slot=0.
- CH_SLOT:
  - sram_a = {slot, ch_sram_a[slot]}, sram_we=0.
  - If slot>0, latch sram_q into wave_data[slot-1].
  - If slot==NUM_CH-1, go to CPU_SLOT; otherwise slot+1.
- CPU_SLOT:
  - Latch sram_q into wave_data[NUM_CH-1].
  - If cpu_req=1, drive sram_a=cpu_a, and for a write drive sram_we=1 and sram_d=cpu_wdata.
  - If cpu_req=0, sram_a=0 and sram_we=0.
  - Record whether the slot was granted. Go to DONE.
- DONE:
  - sample_valid=1.
  - If the slot was granted: cpu_ack=1, and for a read cpu_rdata=sram_q. For a write, cpu_rdata holds its previous value.
  - Go to IDLE.
- Latency: `active` at cycle T → sample_valid and cpu_ack at cycle T+NUM_CH+2.
- The minimum active spacing is NUM_CH+3 clk.
- cpu_req is sampled only in CPU_SLOT. The requester must drop cpu_req in the cycle after cpu_ack. If it is still high at the next CPU_SLOT, that is a new access.
- active=1 in any state other than IDLE: the pulse is ignored, the scan continues unchanged, and overrun is set to 1. overrun clears only on reset.
- active=1 in the same cycle as a DONE→IDLE transition is treated as an overrun. The scan restarts only from IDLE.
- sram_we is 1 only in a granted CPU write slot; it is never asserted in a channel slot.
- wave_data entries change only at their own latch cycle and hold otherwise.

Optional Feature:
- Macro: WTS_CH_MUTE_SKIP_EN.
- Defined: a channel slot whose ch_mute[slot]=1 still occupies its cycle, so timing is unchanged. sram_a is driven to 0 in that slot, and the corresponding wave_data entry is written 8'h00 instead of sram_q.
- Not defined: ch_mute is ignored, every channel is read from SRAM, and the port exists but is unused.

Decomposition:
- Shared package `wts_pkg`:
  - state encoding constants (IDLE=0, CH_SLOT=1, CPU_SLOT=2, DONE=3);
  - WAVE_ADDR_W=7 and SAMPLE_W=8;
  - the default NUM_CH.
- One natural sub-module: `wts_sample_latch`, the per-channel wave_data register bank with a write-enable and index decode. The FSM stays in the top module.

Test Plan:
- Basic scan, NUM_CH=5:
  - Stimulus: ch_sram_a = 7'h10,7'h11,7'h12,7'h13,7'h14; SRAM model returns a[7:0]^8'hA5; active at T.
  - Required: sram_a = 10'h010, 10'h091, 10'h112, 10'h193, 10'h214 at T+1..T+5; wave_data[i] = model data for each address; sample_valid at T+7.
- CPU write:
  - Stimulus: cpu_req=1, cpu_wr=1, cpu_a=10'h0C5, cpu_wdata=8'h3C before active.
  - Required: sram_we=1 only at T+6 with sram_d=8'h3C; cpu_ack at T+7; SRAM holds 8'h3C at 10'h0C5.
- CPU read:
  - Stimulus: cpu read of 10'h0C5 after the write above.
  - Required: cpu_rdata=8'h3C with cpu_ack at T+7; sram_we stays 0 for the whole scan.
- Overrun:
  - Stimulus: second active pulse at T+3.
  - Required: scan timing unchanged, overrun=1 from T+4, no extra scan; overrun stays 1 until nreset=0.
- Reset mid-scan:
  - Stimulus: pending CPU write; nreset=0 at T+6, then released.
  - Required: sram_we=0 from the next edge; no cpu_ack; wave_data and all outputs 0; the next active performs a normal scan and grants the re-presented request.
- Mute (WTS_CH_MUTE_SKIP_EN):
  - Stimulus: ch_mute=5'b00100.
  - Required: sram_a=0 at T+3, wave_data[2]=8'h00, other channels normal. Without the macro, wave_data[2] holds the SRAM data.
